// File: rtl/sif_pkg.sv
// Shared types for the XA-to-WA request bridge: FSM states, the XA op
// decode and the queued request layout.
package sif_pkg;

    // Default widths of the bridge; s_sif_req is laid out at these widths.
    localparam int SIF_ADDR_W = 8;
    localparam int SIF_DATA_W = 16;

    typedef enum logic {
        S_IDLE,
        S_WAIT_ACK
    } E_BridgeState;

    // Encoding matches {xa_wr_s, xa_rd_s} bit for bit.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } e_sif_op;

    // A queued request: only WRITE/READ are ever stored, so one bit of op suffices.
    typedef struct packed {
        logic                  is_write;
        logic [SIF_ADDR_W-1:0] addr;
        logic [SIF_DATA_W-1:0] wdata;
    } s_sif_req;

    function automatic e_sif_op decode_op(input logic wr_s, input logic rd_s);
        return e_sif_op'({wr_s, rd_s});
    endfunction

endpackage

// File: rtl/sif_req_fifo.sv
// Request queue: DEPTH entries (power of two), pointers wrap modulo DEPTH,
// count runs 0..DEPTH. Push while full and pop while empty are ignored.
module sif_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Entry storage.
    // NOTE: the array has no reset; an entry is never read before it is written, so clearing it only costs logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sif_xa_bridge.sv
// XA-to-WA bridge: queues XA WRITE/READ requests and replays them in order
// as single strobed WA transactions, returning read data to XA.
// Optional macro SIF_BRIDGE_TIMEOUT_EN: abandon a WA transfer after TIMEOUT
// cycles without wa_ack and report it on xa_err.
module sif_xa_bridge
    import sif_pkg::*;
#(
    parameter int ADDR_W  = SIF_ADDR_W,
    parameter int DATA_W  = SIF_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              xa_wr_s,
    input  logic              xa_rd_s,
    input  logic [ADDR_W-1:0] xa_addr,
    input  logic [DATA_W-1:0] xa_wdata,
    output logic              xa_ready,
    output logic [DATA_W-1:0] xa_rdata,
    output logic              xa_rvalid,
    output logic              xa_err,
    output logic              wa_wr_s,
    output logic              wa_rd_s,
    output logic [ADDR_W-1:0] wa_addr,
    output logic [DATA_W-1:0] wa_wdata,
    input  logic              wa_ack,
    input  logic [DATA_W-1:0] wa_rdata
);

    // Same field order as s_sif_req, sized by this instance's parameters.
    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    E_BridgeState state, state_next;
    e_sif_op      op;
    req_t         push_req;
    req_t         head;
    logic         full, empty;
    logic         push, pop;
    logic         wr_next, rd_next, rvalid_next, err_next;
    logic         load_wa, load_rdata;
    logic         timed_out;

    assign op       = decode_op(xa_wr_s, xa_rd_s);
    assign xa_ready = !full;
    assign push     = ((op == OP_WRITE) || (op == OP_READ)) && xa_ready;
    assign push_req = '{is_write: (op == OP_WRITE), addr: xa_addr, wdata: xa_wdata};

    sif_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (1 + ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef SIF_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign timed_out = (state == S_WAIT_ACK) && !wa_ack && (to_cnt == TO_W'(TIMEOUT - 1));

    // Cycles spent waiting for wa_ack; restarts at zero for every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_WAIT_ACK && state_next == S_WAIT_ACK) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timed_out      = 1'b0;
`endif

    // Next-state and next-output decode for the WA transfer FSM.
    // NOTE: every output gets a default first so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        wr_next     = wa_wr_s;
        rd_next     = wa_rd_s;
        rvalid_next = 1'b0;
        err_next    = (op == OP_ILLEGAL);
        load_wa     = 1'b0;
        load_rdata  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    load_wa    = 1'b1;
                    wr_next    = head.is_write;
                    rd_next    = !head.is_write;
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (wa_ack) begin
                    wr_next     = 1'b0;
                    rd_next     = 1'b0;
                    rvalid_next = wa_rd_s;
                    load_rdata  = wa_rd_s;
                    state_next  = S_IDLE;
                end else if (timed_out) begin
                    wr_next    = 1'b0;
                    rd_next    = 1'b0;
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and registered XA/WA outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wa_wr_s   <= 1'b0;
            wa_rd_s   <= 1'b0;
            wa_addr   <= '0;
            wa_wdata  <= '0;
            xa_rdata  <= '0;
            xa_rvalid <= 1'b0;
            xa_err    <= 1'b0;
        end else begin
            state     <= state_next;
            wa_wr_s   <= wr_next;
            wa_rd_s   <= rd_next;
            xa_rvalid <= rvalid_next;
            xa_err    <= err_next;
            if (load_wa) begin
                wa_addr  <= head.addr;
                wa_wdata <= head.wdata;
            end
            if (load_rdata) begin
                xa_rdata <= wa_rdata;
            end
        end
    end

endmodule
